// File: rtl/fp_operand_loader.sv
// Operand-entry stage for the FP add/sub datapath: debounces the save button, assembles
// operands A/B byte-by-byte from the switches and offers the pair downstream on valid/ready.
module fp_operand_loader #(
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        save_btn,
    input  logic        datawork,
    input  logic        selnum,
    input  logic [1:0]  seldata,
    input  logic [7:0]  datain,
    input  logic        clr,
    input  logic        op_ready,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [3:0]  mask_a,
    output logic [3:0]  mask_b,
    output logic        op_valid,
    output logic        err_incomplete,
    output logic [3:0]  leds
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {LOAD, HANDOFF, SPENT} state_t;

    state_t           state, state_n;
    logic             sync1, sync2, deb, deb_d;
    logic [CNT_W-1:0] cnt;
    logic             save_pulse_c;
    logic             wr_en_c;
    logic             full_c;

    logic [31:0] op_a_n, op_b_n;
    logic [3:0]  mask_a_n, mask_b_n, leds_n;
    logic        valid_n, err_n;

    // Synchronizer, stability counter and edge detector for the save button
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            deb   <= 1'b0;
            deb_d <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= save_btn;
            sync2 <= sync1;
            deb_d <= deb;
            if (sync2 == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                deb <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign save_pulse_c = deb & ~deb_d;
    assign full_c       = (&mask_a) & (&mask_b);
    assign wr_en_c      = (state == LOAD) && save_pulse_c && datawork && !clr;

    always_ff @(posedge clk) begin
        if (!reset) state <= LOAD;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            LOAD:    if (!datawork && !clr && full_c) state_n = HANDOFF;
            HANDOFF: if (op_ready)                    state_n = SPENT;
            SPENT:   if (datawork)                    state_n = LOAD;
            default:                                  state_n = LOAD;
        endcase
    end

    // Next values of the registered outputs; operands only change while in LOAD
    always_comb begin
        op_a_n   = op_a;
        op_b_n   = op_b;
        mask_a_n = mask_a;
        mask_b_n = mask_b;
        err_n    = err_incomplete;
        if (state == LOAD) begin
            if (clr) begin
                op_a_n   = '0;
                op_b_n   = '0;
                mask_a_n = '0;
                mask_b_n = '0;
                err_n    = 1'b0;
            end else if (wr_en_c) begin
                for (int i = 0; i < 4; i++) begin
                    if (seldata == 2'(i)) begin
                        if (selnum) begin
                            op_b_n[i*8 +: 8] = datain;
                            mask_b_n[i]      = 1'b1;
                        end else begin
                            op_a_n[i*8 +: 8] = datain;
                            mask_a_n[i]      = 1'b1;
                        end
                    end
                end
                err_n = 1'b0;
            end else if (!datawork && !full_c) begin
                err_n = 1'b1;
            end
        end
        valid_n = (state_n == HANDOFF);
        leds_n  = {valid_n, err_n, &mask_b_n, &mask_a_n};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            op_a           <= '0;
            op_b           <= '0;
            mask_a         <= '0;
            mask_b         <= '0;
            op_valid       <= 1'b0;
            err_incomplete <= 1'b0;
            leds           <= '0;
        end else begin
            op_a           <= op_a_n;
            op_b           <= op_b_n;
            mask_a         <= mask_a_n;
            mask_b         <= mask_b_n;
            op_valid       <= valid_n;
            err_incomplete <= err_n;
            leds           <= leds_n;
        end
    end

endmodule

// File: tb/tb_fp_operand_loader.sv
// Directed bench for fp_operand_loader: stimulus pushes expected snapshots and transfers
// into queues; monitors compare them against the DUT on the falling clock edge.
module tb_fp_operand_loader;

    localparam int unsigned DC = 4;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ma;
        logic [3:0]  mb;
        logic        v;
        logic        e;
        logic [3:0]  leds;
    } snap_t;

    logic        clk = 1'b0;
    logic        reset, save_btn, datawork, selnum, clr, op_ready;
    logic [1:0]  seldata;
    logic [7:0]  datain;
    logic [31:0] op_a, op_b;
    logic [3:0]  mask_a, mask_b, leds;
    logic        op_valid, err_incomplete;

    int n_checks = 0;
    int n_fail   = 0;

    snap_t  exp_q[$];
    string  name_q[$];
    logic [63:0] xfer_q[$];

    logic [31:0] m_a, m_b;
    logic [3:0]  m_ma, m_mb;
    logic        m_v, m_err;

    fp_operand_loader #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .save_btn(save_btn), .datawork(datawork),
        .selnum(selnum), .seldata(seldata), .datain(datain), .clr(clr),
        .op_ready(op_ready), .op_a(op_a), .op_b(op_b), .mask_a(mask_a),
        .mask_b(mask_b), .op_valid(op_valid), .err_incomplete(err_incomplete),
        .leds(leds)
    );

    always #5 clk = ~clk;

    // Snapshot and transfer monitor
    snap_t       mon_e, mon_act;
    string       mon_n;
    logic [63:0] mon_x;
    always @(negedge clk) begin
        mon_act = '{a: op_a, b: op_b, ma: mask_a, mb: mask_b, v: op_valid,
                    e: err_incomplete, leds: leds};
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            n_checks++;
            if (mon_act !== mon_e) begin
                n_fail++;
                $display("FAIL %s: got a=%h b=%h ma=%h mb=%h v=%b err=%b leds=%b, want a=%h b=%h ma=%h mb=%h v=%b err=%b leds=%b",
                         mon_n, mon_act.a, mon_act.b, mon_act.ma, mon_act.mb, mon_act.v, mon_act.e, mon_act.leds,
                         mon_e.a, mon_e.b, mon_e.ma, mon_e.mb, mon_e.v, mon_e.e, mon_e.leds);
            end
        end
        if (op_valid === 1'b1 && op_ready === 1'b1) begin
            n_checks++;
            if (xfer_q.size() == 0) begin
                n_fail++;
                $display("FAIL xfer: unexpected transfer a=%h b=%h", op_a, op_b);
            end else begin
                mon_x = xfer_q.pop_front();
                if ({op_a, op_b} !== mon_x) begin
                    n_fail++;
                    $display("FAIL xfer: got a=%h b=%h, want a=%h b=%h",
                             op_a, op_b, mon_x[63:32], mon_x[31:0]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_snap(input string name);
        exp_q.push_back('{a: m_a, b: m_b, ma: m_ma, mb: m_mb, v: m_v, e: m_err,
                          leds: {m_v, m_err, &m_mb, &m_ma}});
        name_q.push_back(name);
    endtask

    task automatic expect_val(input string name, input snap_t s);
        exp_q.push_back(s);
        name_q.push_back(name);
    endtask

    task automatic model_write(input logic sel, input int lane, input logic [7:0] val);
        if (sel) begin
            m_b[8*lane +: 8] = val;
            m_mb[lane]       = 1'b1;
        end else begin
            m_a[8*lane +: 8] = val;
            m_ma[lane]       = 1'b1;
        end
        m_err = 1'b0;
    endtask

    task automatic model_clear();
        m_a = '0; m_b = '0; m_ma = '0; m_mb = '0; m_v = 1'b0; m_err = 1'b0;
    endtask

    task automatic press();
        save_btn = 1'b1;
        tick(DC + 4);
        save_btn = 1'b0;
        tick(DC + 4);
    endtask

    task automatic write_byte(input logic sel, input int lane, input logic [7:0] val, input string name);
        selnum = sel; seldata = 2'(lane); datain = val;
        press();
        model_write(sel, lane, val);
        expect_snap(name);
    endtask

    // Pulse must land exactly DEBOUNCE_CYCLES+2 edges after the first high sample
    task automatic latency_write(input logic sel, input int lane, input logic [7:0] val);
        selnum = sel; seldata = 2'(lane); datain = val;
        save_btn = 1'b1;
        tick(DC + 2);
        expect_snap("latency_before");
        tick(1);
        model_write(sel, lane, val);
        expect_snap("latency_after");
        save_btn = 1'b0;
        tick(DC + 4);
    endtask

    task automatic load_pi_one();
        write_byte(1'b0, 0, 8'hDB, "ld_a0");
        write_byte(1'b0, 1, 8'h0F, "ld_a1");
        write_byte(1'b0, 2, 8'h49, "ld_a2");
        write_byte(1'b0, 3, 8'h40, "ld_a3");
        write_byte(1'b1, 0, 8'h00, "ld_b0");
        write_byte(1'b1, 1, 8'h00, "ld_b1");
        write_byte(1'b1, 2, 8'h80, "ld_b2");
        write_byte(1'b1, 3, 8'h3F, "ld_b3");
    endtask

    initial begin
        reset = 1'b0; save_btn = 1'b0; datawork = 1'b1; selnum = 1'b0;
        seldata = 2'd0; datain = 8'h00; clr = 1'b0; op_ready = 1'b0;
        model_clear();
        tick(3);
        expect_snap("reset");
        reset = 1'b1;
        tick(1);

        // Bounce shorter than the debounce window
        selnum = 1'b0; seldata = 2'd0; datain = 8'hAA;
        save_btn = 1'b1; tick(2);
        save_btn = 1'b0; tick(2);
        save_btn = 1'b1; tick(2);
        save_btn = 1'b0; tick(12);
        expect_snap("bounce");

        // Full load and handoff
        load_pi_one();
        datawork = 1'b0;
        tick(1);
        m_v = 1'b1;
        expect_val("handoff", '{a: 32'h40490FDB, b: 32'h3F800000, ma: 4'hF, mb: 4'hF,
                                v: 1'b1, e: 1'b0, leds: 4'b1011});
        xfer_q.push_back({32'h40490FDB, 32'h3F800000});

        // Held off for a while: presses, clr and datawork are all ignored
        datawork = 1'b1;
        selnum = 1'b0; seldata = 2'd0; datain = 8'h55;
        press();
        clr = 1'b1; tick(2); clr = 1'b0;
        tick(1);
        expect_snap("handoff_hold");
        datawork = 1'b0;
        tick(1);
        op_ready = 1'b1;
        tick(1);
        op_ready = 1'b0;
        m_v = 1'b0;
        expect_val("spent", '{a: 32'h40490FDB, b: 32'h3F800000, ma: 4'hF, mb: 4'hF,
                              v: 1'b0, e: 1'b0, leds: 4'b0011});
        tick(4);
        expect_snap("spent_hold");
        datawork = 1'b1;
        tick(1);
        write_byte(1'b1, 3, 8'h40, "edit_after_spent");

        // Incomplete operand set
        clr = 1'b1; tick(1); clr = 1'b0;
        model_clear();
        expect_snap("clr");
        write_byte(1'b1, 0, 8'h00, "inc_b0");
        write_byte(1'b1, 1, 8'h00, "inc_b1");
        write_byte(1'b1, 2, 8'h80, "inc_b2");
        datawork = 1'b0;
        tick(2);
        m_err = 1'b1;
        expect_val("incomplete", '{a: 32'h0, b: 32'h00800000, ma: 4'h0, mb: 4'h7,
                                   v: 1'b0, e: 1'b1, leds: 4'b0100});
        datawork = 1'b1;
        tick(2);
        expect_snap("err_sticky");
        write_byte(1'b1, 3, 8'h3F, "err_cleared");

        // Lane overwrite, then clr racing a save pulse
        write_byte(1'b0, 2, 8'h12, "ovw_first");
        latency_write(1'b0, 2, 8'h34);
        expect_val("ovw_second", '{a: 32'h00340000, b: 32'h3F800000, ma: 4'h4, mb: 4'hF,
                                   v: 1'b0, e: 1'b0, leds: 4'b0010});
        selnum = 1'b0; seldata = 2'd1; datain = 8'h77;
        save_btn = 1'b1;
        tick(DC + 1);
        clr = 1'b1;
        tick(3);
        clr = 1'b0;
        save_btn = 1'b0;
        tick(DC + 4);
        model_clear();
        expect_snap("clr_beats_pulse");

        // Reset while in HANDOFF
        load_pi_one();
        datawork = 1'b0;
        tick(1);
        m_v = 1'b1;
        expect_snap("handoff2");
        tick(1);
        reset = 1'b0;
        datawork = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(1);
        model_clear();
        expect_snap("reset_handoff");

        // Reset in the middle of a debounce
        selnum = 1'b1; seldata = 2'd0; datain = 8'hC3;
        save_btn = 1'b1;
        tick(DC + 1);
        reset = 1'b0;
        save_btn = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(DC + 6);
        expect_snap("reset_debounce");

        tick(3);
        n_checks++;
        if (exp_q.size() != 0 || xfer_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d snapshots and %0d transfers pending, want 0 and 0",
                     exp_q.size(), xfer_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
